// File: rtl/mure_pkg.sv
// Shared widths and trap payload for the trace front end.
package mure_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INST_LEN  = 32;
    localparam int unsigned CAUSE_LEN = 5;

    // Trap portion of a retirement bundle.
    typedef struct packed {
        logic                 exception;
        logic                 interrupt;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [XLEN-1:0]      epc;
    } trap_t;

endpackage

// File: rtl/mure_retire_serializer.sv
// Buffers multi-lane retirement bundles and drains them as one record per cycle,
// oldest lane first, with the bundle's trap (if any) as its final record.
module mure_retire_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = 2,
    parameter int unsigned FifoDepth      = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrRetiredInstr-1:0]          valids_i,
    input  logic [NrRetiredInstr*INST_LEN-1:0] insts_i,
    input  logic [NrRetiredInstr*XLEN-1:0]     pcs_i,
    input  logic                               exception_i,
    input  logic                               interrupt_i,
    input  logic [CAUSE_LEN-1:0]               cause_i,
    input  logic [XLEN-1:0]                    tval_i,
    input  logic [XLEN-1:0]                    epc_i,
    output logic                               ready_o,
    output logic                               overflow_o,
    input  logic                               ready_i,
    output logic                               inst_valid_o,
    output logic                               iretired_o,
    output logic                               exception_o,
    output logic                               interrupt_o,
    output logic [INST_LEN-1:0]                inst_data_o,
    output logic [XLEN-1:0]                    pc_o,
    output logic [CAUSE_LEN-1:0]               cause_o,
    output logic [XLEN-1:0]                    tval_o,
    output logic [XLEN-1:0]                    epc_o
);

    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned LaneW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

    // Bundle storage
    logic [NrRetiredInstr-1:0]          mem_valids [FifoDepth];
    logic [NrRetiredInstr*INST_LEN-1:0] mem_insts  [FifoDepth];
    logic [NrRetiredInstr*XLEN-1:0]     mem_pcs    [FifoDepth];
    trap_t                              mem_trap   [FifoDepth];

    // FIFO control
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_next;
    logic            ready_q;
    logic            overflow_q;

    // Head scan state; fresh_q means the head has not been scanned yet
    logic [NrRetiredInstr-1:0] mask_q;
    logic                      trap_done_q;
    logic                      fresh_q;

    // Output record register
    logic                 valid_q;
    logic                 iretired_q;
    logic                 exception_q;
    logic                 interrupt_q;
    logic [INST_LEN-1:0]  inst_q;
    logic [XLEN-1:0]      pc_q;
    logic [CAUSE_LEN-1:0] cause_q;
    logic [XLEN-1:0]      tval_q;
    logic [XLEN-1:0]      epc_q;

    // Combinational scan results
    logic                      push;
    logic                      push_acc;
    logic                      advance;
    logic                      nonempty;
    logic                      pop;
    logic [NrRetiredInstr-1:0] head_valids;
    logic [NrRetiredInstr*INST_LEN-1:0] head_insts;
    logic [NrRetiredInstr*XLEN-1:0]     head_pcs;
    trap_t                     head_trap;
    logic                      head_has_trap;
    logic [NrRetiredInstr-1:0] eff_mask;
    logic [NrRetiredInstr-1:0] rest_mask;
    logic                      eff_trap_done;
    logic                      found;
    logic [LaneW-1:0]          sel_lane;
    logic                      emit_inst;
    logic                      emit_trap;
    logic                      last;
    logic [INST_LEN-1:0]       sel_inst;
    logic [XLEN-1:0]           sel_pc;

    assign push     = (|valids_i) | exception_i | interrupt_i;
    assign push_acc = push & ready_q;
    assign advance  = ~valid_q | ready_i;
    assign nonempty = (count_q != '0);

    assign head_valids   = mem_valids[rd_ptr_q];
    assign head_insts    = mem_insts[rd_ptr_q];
    assign head_pcs      = mem_pcs[rd_ptr_q];
    assign head_trap     = mem_trap[rd_ptr_q];
    assign head_has_trap = head_trap.exception | head_trap.interrupt;

    // Pick the next record from the head bundle and decide whether it is the last one
    always_comb begin
        eff_mask      = fresh_q ? head_valids : mask_q;
        eff_trap_done = fresh_q ? 1'b0 : trap_done_q;
        found         = 1'b0;
        sel_lane      = '0;
        for (int unsigned i = 0; i < NrRetiredInstr; i++) begin
            if (!found && eff_mask[i]) begin
                found    = 1'b1;
                sel_lane = LaneW'(i);
            end
        end
        rest_mask = eff_mask;
        if (found) begin
            rest_mask[sel_lane] = 1'b0;
        end
        emit_inst  = nonempty & found;
        emit_trap  = nonempty & ~found & head_has_trap & ~eff_trap_done;
        last       = ~found | ((rest_mask == '0) & ~head_has_trap);
        pop        = advance & nonempty & last;
        count_next = count_q + CntW'(push_acc) - CntW'(pop);
        sel_inst   = head_insts[32'(sel_lane) * INST_LEN +: INST_LEN];
        sel_pc     = head_pcs[32'(sel_lane) * XLEN +: XLEN];
    end

    // Bundle write port; storage needs no reset since count gates every read
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_valids[wr_ptr_q] <= valids_i;
            mem_insts[wr_ptr_q]  <= insts_i;
            mem_pcs[wr_ptr_q]    <= pcs_i;
            mem_trap[wr_ptr_q]   <= '{exception: exception_i,
                                      interrupt: interrupt_i,
                                      cause:     cause_i,
                                      tval:      tval_i,
                                      epc:       epc_i};
        end
    end

    // FIFO pointers, occupancy, ready and overflow flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_next;
            ready_q    <= (count_next < CntW'(FifoDepth));
            overflow_q <= push & ~ready_q;
        end
    end

    // Head scan progress: remaining lanes and trap emission
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q      <= '0;
            trap_done_q <= 1'b0;
            fresh_q     <= 1'b1;
        end else if (advance && nonempty) begin
            if (pop) begin
                mask_q      <= '0;
                trap_done_q <= 1'b0;
                fresh_q     <= 1'b1;
            end else begin
                mask_q      <= rest_mask;
                trap_done_q <= eff_trap_done | emit_trap;
                fresh_q     <= 1'b0;
            end
        end
    end

    // Output record register; holds while the encoder stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            iretired_q  <= 1'b0;
            exception_q <= 1'b0;
            interrupt_q <= 1'b0;
            inst_q      <= '0;
            pc_q        <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            epc_q       <= '0;
        end else if (advance) begin
            valid_q     <= emit_inst | emit_trap;
            iretired_q  <= emit_inst;
            exception_q <= emit_trap & head_trap.exception;
            interrupt_q <= emit_trap & head_trap.interrupt & ~head_trap.exception;
            inst_q      <= emit_inst ? sel_inst : '0;
            pc_q        <= emit_inst ? sel_pc : '0;
            cause_q     <= emit_trap ? head_trap.cause : '0;
            tval_q      <= emit_trap ? head_trap.tval : '0;
            epc_q       <= emit_trap ? head_trap.epc : '0;
        end
    end

    assign ready_o      = ready_q;
    assign overflow_o   = overflow_q;
    assign inst_valid_o = valid_q;
    assign iretired_o   = iretired_q;
    assign exception_o  = exception_q;
    assign interrupt_o  = interrupt_q;
    assign inst_data_o  = inst_q;
    assign pc_o         = pc_q;
    assign cause_o      = cause_q;
    assign tval_o       = tval_q;
    assign epc_o        = epc_q;

endmodule

// File: tb/tb_mure_retire_serializer.sv
// Directed bench for the retirement serializer (2 lanes, 4-deep FIFO).
module tb_mure_retire_serializer;
    import mure_pkg::*;

    localparam int unsigned N     = 2;
    localparam int unsigned Depth = 4;

    typedef struct packed {
        logic [2:0]           kind;   // {interrupt, exception, iretired}
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      tval;
        logic [XLEN-1:0]      epc;
    } rec_t;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [N-1:0]           valids_i;
    logic [N*INST_LEN-1:0]  insts_i;
    logic [N*XLEN-1:0]      pcs_i;
    logic                   exception_i;
    logic                   interrupt_i;
    logic [CAUSE_LEN-1:0]   cause_i;
    logic [XLEN-1:0]        tval_i;
    logic [XLEN-1:0]        epc_i;
    logic                   ready_o;
    logic                   overflow_o;
    logic                   ready_i;
    logic                   inst_valid_o;
    logic                   iretired_o;
    logic                   exception_o;
    logic                   interrupt_o;
    logic [INST_LEN-1:0]    inst_data_o;
    logic [XLEN-1:0]        pc_o;
    logic [CAUSE_LEN-1:0]   cause_o;
    logic [XLEN-1:0]        tval_o;
    logic [XLEN-1:0]        epc_o;

    int   tests_run    = 0;
    int   tests_failed = 0;
    rec_t recs[$];

    mure_retire_serializer #(.NrRetiredInstr(N), .FifoDepth(Depth)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valids_i(valids_i), .insts_i(insts_i),
        .pcs_i(pcs_i), .exception_i(exception_i), .interrupt_i(interrupt_i),
        .cause_i(cause_i), .tval_i(tval_i), .epc_i(epc_i), .ready_o(ready_o),
        .overflow_o(overflow_o), .ready_i(ready_i), .inst_valid_o(inst_valid_o),
        .iretired_o(iretired_o), .exception_o(exception_o), .interrupt_o(interrupt_o),
        .inst_data_o(inst_data_o), .pc_o(pc_o), .cause_o(cause_o), .tval_o(tval_o),
        .epc_o(epc_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        valids_i    = '0;
        insts_i     = '0;
        pcs_i       = '0;
        exception_i = 1'b0;
        interrupt_i = 1'b0;
        cause_i     = '0;
        tval_i      = '0;
        epc_i       = '0;
    endtask

    // Drive one bundle for a single cycle; opcode of each lane is ~pc. Returns at the negedge after the write edge.
    task automatic push_bundle(input logic [N-1:0] v, input logic [XLEN-1:0] p0, input logic [XLEN-1:0] p1,
                               input logic exc, input logic irq, input logic [CAUSE_LEN-1:0] c,
                               input logic [XLEN-1:0] tv, input logic [XLEN-1:0] ep);
        valids_i    = v;
        pcs_i       = {p1, p0};
        insts_i     = {~p1, ~p0};
        exception_i = exc;
        interrupt_i = irq;
        cause_i     = c;
        tval_i      = tv;
        epc_i       = ep;
        step();
        clear_inputs();
    endtask

    // Record every handshaked output record for a bounded number of cycles
    task automatic collect(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (inst_valid_o && ready_i) begin
                recs.push_back('{kind: {interrupt_o, exception_o, iretired_o}, cause: cause_o,
                                 pc: pc_o, tval: tval_o, epc: epc_o});
            end
            step();
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({inst_valid_o, iretired_o, exception_o, interrupt_o, overflow_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 00000",
                     {inst_valid_o, iretired_o, exception_o, interrupt_o, overflow_o});
        end
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", ready_o);
        end
        tests_run++;
        if ({inst_data_o, pc_o, cause_o, tval_o, epc_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: pc %h inst %h cause %h tval %h epc %h want all 0",
                     pc_o, inst_data_o, cause_o, tval_o, epc_o);
        end
    endtask

    task automatic test_two_lanes();
        ready_i = 1'b1;
        push_bundle(2'b11, 32'h1000, 32'h1004, 1'b0, 1'b0, '0, '0, '0);
        tests_run++;
        if (inst_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_lanes_latency: valid %b one cycle after input, want 0", inst_valid_o);
        end
        step();
        tests_run++;
        if ({inst_valid_o, iretired_o, exception_o, pc_o, inst_data_o} !== {3'b110, 32'h1000, 32'hFFFF_EFFF}) begin
            tests_failed++;
            $display("FAIL two_lanes_rec0: valid %b iret %b exc %b pc %h inst %h want 1 1 0 1000 ffffefff",
                     inst_valid_o, iretired_o, exception_o, pc_o, inst_data_o);
        end
        step();
        tests_run++;
        if ({inst_valid_o, iretired_o, pc_o, inst_data_o} !== {2'b11, 32'h1004, 32'hFFFF_EFFB}) begin
            tests_failed++;
            $display("FAIL two_lanes_rec1: valid %b iret %b pc %h inst %h want 1 1 1004 ffffeffb",
                     inst_valid_o, iretired_o, pc_o, inst_data_o);
        end
        step();
        tests_run++;
        if (inst_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_lanes_idle: valid %b want 0", inst_valid_o);
        end
    endtask

    task automatic test_upper_lane();
        push_bundle(2'b10, 32'h0, 32'h2004, 1'b0, 1'b0, '0, '0, '0);
        step();
        tests_run++;
        if ({inst_valid_o, iretired_o, pc_o} !== {2'b11, 32'h2004}) begin
            tests_failed++;
            $display("FAIL upper_lane_rec: valid %b iret %b pc %h want 1 1 2004", inst_valid_o, iretired_o, pc_o);
        end
        step();
        tests_run++;
        if (inst_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL upper_lane_single: valid %b pc %h want 0 (one record only)", inst_valid_o, pc_o);
        end
    endtask

    task automatic test_exception();
        push_bundle(2'b01, 32'h3000, 32'h0, 1'b1, 1'b0, 5'd2, 32'hDEAD, 32'h3004);
        step();
        tests_run++;
        if ({inst_valid_o, iretired_o, exception_o, pc_o, cause_o, tval_o} !== {3'b110, 32'h3000, 5'd0, 32'h0}) begin
            tests_failed++;
            $display("FAIL exc_inst_rec: valid %b iret %b exc %b pc %h cause %h tval %h want 1 1 0 3000 0 0",
                     inst_valid_o, iretired_o, exception_o, pc_o, cause_o, tval_o);
        end
        step();
        tests_run++;
        if ({inst_valid_o, iretired_o, exception_o, interrupt_o} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL exc_trap_flags: valid/iret/exc/irq %b want 1010",
                     {inst_valid_o, iretired_o, exception_o, interrupt_o});
        end
        tests_run++;
        if ({cause_o, tval_o, epc_o, pc_o, inst_data_o} !== {5'd2, 32'hDEAD, 32'h3004, 32'h0, 32'h0}) begin
            tests_failed++;
            $display("FAIL exc_trap_data: cause %h tval %h epc %h pc %h inst %h want 2 dead 3004 0 0",
                     cause_o, tval_o, epc_o, pc_o, inst_data_o);
        end
        step();
        tests_run++;
        if (inst_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL exc_idle: valid %b want 0", inst_valid_o);
        end
    endtask

    task automatic test_trap_priority();
        push_bundle(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h11, 32'h22);
        step();
        tests_run++;
        if ({inst_valid_o, iretired_o, exception_o, interrupt_o, cause_o, epc_o} !== {4'b1010, 5'd7, 32'h22}) begin
            tests_failed++;
            $display("FAIL both_traps: valid/iret/exc/irq %b cause %h epc %h want 1010 7 22",
                     {inst_valid_o, iretired_o, exception_o, interrupt_o}, cause_o, epc_o);
        end
        step();
        push_bundle(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h44);
        step();
        tests_run++;
        if ({inst_valid_o, iretired_o, exception_o, interrupt_o, cause_o, epc_o} !== {4'b1001, 5'd5, 32'h44}) begin
            tests_failed++;
            $display("FAIL irq_trap: valid/iret/exc/irq %b cause %h epc %h want 1001 5 44",
                     {inst_valid_o, iretired_o, exception_o, interrupt_o}, cause_o, epc_o);
        end
        step();
        tests_run++;
        if (inst_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_idle: valid %b want 0", inst_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] exp_pc [3];
        exp_pc[0] = 32'h7000;
        exp_pc[1] = 32'h7004;
        exp_pc[2] = 32'h7100;
        push_bundle(2'b11, 32'h7000, 32'h7004, 1'b0, 1'b0, '0, '0, '0);
        push_bundle(2'b01, 32'h7100, 32'h0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({inst_valid_o, pc_o} !== {1'b1, exp_pc[i]}) begin
                tests_failed++;
                $display("FAIL b2b_rec%0d: valid %b pc %h want 1 %h", i, inst_valid_o, pc_o, exp_pc[i]);
            end
            step();
        end
        tests_run++;
        if (inst_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: valid %b want 0", inst_valid_o);
        end
    endtask

    task automatic test_stall();
        push_bundle(2'b11, 32'h4000, 32'h4004, 1'b1, 1'b0, 5'd3, 32'h44, 32'h4008);
        step();
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if ({inst_valid_o, iretired_o, exception_o, pc_o, inst_data_o} !== {3'b110, 32'h4000, 32'hFFFF_BFFF}) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: valid %b iret %b exc %b pc %h inst %h want 1 1 0 4000 ffffbfff",
                         c, inst_valid_o, iretired_o, exception_o, pc_o, inst_data_o);
            end
        end
        ready_i = 1'b1;
        recs.delete();
        collect(6);
        tests_run++;
        if (recs.size() !== 3) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d records want 3", recs.size());
        end
        if (recs.size() >= 3) begin
            tests_run++;
            if (recs[0] !== rec_t'{kind: 3'b001, cause: 5'd0, pc: 32'h4000, tval: 32'h0, epc: 32'h0}) begin
                tests_failed++;
                $display("FAIL stall_rec0: got %h want lane0 pc 4000", recs[0]);
            end
            tests_run++;
            if (recs[1] !== rec_t'{kind: 3'b001, cause: 5'd0, pc: 32'h4004, tval: 32'h0, epc: 32'h0}) begin
                tests_failed++;
                $display("FAIL stall_rec1: got %h want lane1 pc 4004", recs[1]);
            end
            tests_run++;
            if (recs[2] !== rec_t'{kind: 3'b010, cause: 5'd3, pc: 32'h0, tval: 32'h44, epc: 32'h4008}) begin
                tests_failed++;
                $display("FAIL stall_trap: got %h want exc cause 3 tval 44 epc 4008", recs[2]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [XLEN-1:0] exp_pc;
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_bundle(2'b11, 32'h5000 + 32'(k) * 32'h10, 32'h5004 + 32'(k) * 32'h10,
                        1'b0, 1'b0, '0, '0, '0);
        end
        tests_run++;
        if ({ready_o, overflow_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL ovf_full: ready %b overflow %b want 0 0", ready_o, overflow_o);
        end
        push_bundle(2'b11, 32'h5040, 32'h5044, 1'b0, 1'b0, '0, '0, '0);
        tests_run++;
        if ({overflow_o, ready_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL ovf_pulse: overflow %b ready %b want 1 0", overflow_o, ready_o);
        end
        step();
        tests_run++;
        if ({overflow_o, inst_valid_o, pc_o} !== {2'b01, 32'h5000}) begin
            tests_failed++;
            $display("FAIL ovf_one_pulse: overflow %b valid %b pc %h want 0 1 5000", overflow_o, inst_valid_o, pc_o);
        end
        ready_i = 1'b1;
        recs.delete();
        collect(12);
        tests_run++;
        if (recs.size() !== 8) begin
            tests_failed++;
            $display("FAIL ovf_drain_count: got %0d records want 8", recs.size());
        end
        for (int i = 0; i < recs.size() && i < 8; i++) begin
            exp_pc = 32'h5000 + 32'(i / 2) * 32'h10 + 32'(i % 2) * 32'h4;
            tests_run++;
            if ({recs[i].kind, recs[i].pc} !== {3'b001, exp_pc}) begin
                tests_failed++;
                $display("FAIL ovf_drain%0d: kind %b pc %h want 001 %h", i, recs[i].kind, recs[i].pc, exp_pc);
            end
        end
        tests_run++;
        if ({inst_valid_o, ready_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL ovf_empty: valid %b ready %b want 0 1", inst_valid_o, ready_o);
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        push_bundle(2'b11, 32'h6000, 32'h6004, 1'b0, 1'b0, '0, '0, '0);
        step();
        tests_run++;
        if ({inst_valid_o, pc_o} !== {1'b1, 32'h6000}) begin
            tests_failed++;
            $display("FAIL rstmid_pre: valid %b pc %h want 1 6000", inst_valid_o, pc_o);
        end
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({inst_valid_o, iretired_o, exception_o, interrupt_o, overflow_o, ready_o} !== 6'b000001) begin
            tests_failed++;
            $display("FAIL rstmid_flags: valid/iret/exc/irq/ovf/ready %b want 000001",
                     {inst_valid_o, iretired_o, exception_o, interrupt_o, overflow_o, ready_o});
        end
        tests_run++;
        if ({inst_data_o, pc_o, cause_o, tval_o, epc_o} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_data: pc %h inst %h want 0", pc_o, inst_data_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        recs.delete();
        collect(6);
        tests_run++;
        if (recs.size() !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_stale: got %0d records after reset want 0", recs.size());
        end
    endtask

    initial begin
        clear_inputs();
        ready_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (2) @(negedge clk_i);
        test_reset();
        rst_ni = 1'b1;
        step();
        test_two_lanes();
        test_upper_lane();
        test_exception();
        test_trap_priority();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
